uart_counter_receiver: RTL
==========================

Name: uart_counter_receiver

Overview:
- Receive side of the one-byte counter-reporting UART link: recovers 8N1 frames (start, 8 data bits LSB first, stop), presents the byte, and extracts the counter field.
- Sits at the host/monitor end of the link, or in loopback test logic, opposite the counter transmitter.
- The transmitter shifts one bit per clock on the falling edge. This block samples on the rising edge, i.e. mid-bit, when CLKS_PER_BIT=1.

Parameters:
- INPUT_FEATURES, 8, number of pwm channels; counter field width W = $clog2(INPUT_FEATURES+1), max 8.
- CLKS_PER_BIT, 1, clock cycles per UART bit; legal range 1..255.

Ports:
- clock_i  input  1  system clock; all state updates on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- uart_receive_i  input  1  serial line; idle HIGH.
- data_o  output  8  last correctly framed byte.
- counter_o  output  W  data_o[W-1:0] of last good frame.
- data_valid_o  output  1  one-cycle pulse: new byte on data_o/counter_o.
- overflow_o  output  1  held with data_valid_o: data_o[7:W] nonzero (field out of range).
- frame_error_o  output  1  one-cycle pulse: stop bit sampled LOW.
- busy_o  output  1  high from start detect until return to IDLE.

Behaviour:
- Reset is asynchronous and active-high. Reset values: all outputs 0, state IDLE, shift register 0, bit index 0, cycle counter 0.
- Reset mid-frame aborts the frame with no pulse. The first frame is accepted only after uart_receive_i has been seen HIGH in IDLE; a line held LOW across reset release is ignored until it goes HIGH.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx=0 (after a prior HIGH) -> busy_o=1.
  - CLKS_PER_BIT=1: go straight to DATA.
  - Otherwise: go to START with cycle counter = 0.
- START: count (CLKS_PER_BIT-1)/2 cycles, then re-sample rx.
  - rx=0 -> DATA; cycle counter reset.
  - rx=1 -> glitch: back to IDLE, no pulse.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx into shift[bit_idx], bit_idx++ (3-bit, LSB first).
  - After the bit_idx=7 sample, go to STOP.
- STOP: sample rx after CLKS_PER_BIT cycles.
  - rx=1 -> on the same edge register data_o=shift, counter_o=shift[W-1:0], overflow_o=|shift[7:W] (0 when W=8), data_valid_o=1; then IDLE.
  - rx=0 -> frame_error_o=1, data_o/counter_o unchanged; go to BREAK.
- BREAK: wait for rx=1, then IDLE. No start detection while in BREAK.
- Pulses: data_valid_o and frame_error_o are high exactly one cycle and never high together. overflow_o follows data_valid_o.
- Latency at CLKS_PER_BIT=1, with start detected at edge S:
  - data bits sampled at S+1..S+8, stop bit at S+9;
  - data_valid_o high during the cycle after edge S+9.
- Back-to-back frames: at CLKS_PER_BIT=1, a start bit sampled on the edge after the stop sample is accepted (IDLE is entered at S+9 and checks rx at S+10). No dead cycles are required beyond that.
- busy_o clears on the edge that enters IDLE.

Optional Feature:
- Macro: UART_RECEIVER_SYNC_EN.
- Defined: uart_receive_i passes through a 2-flop synchronizer, reset to 1, before any use. All latencies grow by 2 cycles.
- Undefined: rx is used directly; the line is assumed synchronous to clock_i, as in on-chip loopback.

Test Plan:
- Idle line after reset, no stimulus, 50 cycles -> all outputs 0, busy_o=0.
- CLKS_PER_BIT=1, frame byte 0x05 (line 0,1,0,1,0,0,0,0,0,1) -> data_o=0x05, counter_o=5, overflow_o=0, data_valid_o high for 1 cycle at S+10.
- CLKS_PER_BIT=4, frame byte 0xA3 -> data_o=0xA3, counter_o=0x3 (W=4), overflow_o=1. A 1-cycle LOW glitch on an idle line produces no pulse and returns to IDLE.
- Frame 0x07 with stop bit LOW, line held LOW 5 more cycles, then a good 0x02 frame -> frame_error_o 1-cycle pulse, data_o stays at previous value, BREAK until HIGH, then data_o=0x02 valid.
- Two back-to-back frames 0x01, 0x08 with zero idle at CLKS_PER_BIT=1 -> two data_valid_o pulses 10 cycles apart, counter_o 1 then 8.
- reset_i asserted asynchronously mid-DATA (between edges) -> outputs 0 immediately, no data_valid_o. Next clean frame 0x03 -> received correctly.

Source files
------------

// File: rtl/uart_counter_receiver_if.sv
// Receiver-side bundle: serial line in, framed byte and counter field out.
// slave is the receiver's view; master is the line driver / consumer view.
interface uart_counter_receiver_if #(
  parameter int unsigned INPUT_FEATURES = 8
);
  localparam int unsigned W = $clog2(INPUT_FEATURES + 1);

  logic         uart_receive_i;
  logic [7:0]   data_o;
  logic [W-1:0] counter_o;
  logic         data_valid_o;
  logic         overflow_o;
  logic         frame_error_o;
  logic         busy_o;

  modport master (
    output uart_receive_i,
    input  data_o,
    input  counter_o,
    input  data_valid_o,
    input  overflow_o,
    input  frame_error_o,
    input  busy_o
  );

  modport slave (
    input  uart_receive_i,
    output data_o,
    output counter_o,
    output data_valid_o,
    output overflow_o,
    output frame_error_o,
    output busy_o
  );
endinterface

// File: rtl/uart_counter_receiver.sv
// 8N1 receiver for the counter-reporting link: recovers a byte and its counter field.
// Define UART_RECEIVER_SYNC_EN to pass the line through a 2-flop synchronizer first.
module uart_counter_receiver #(
  parameter int unsigned INPUT_FEATURES = 8,
  parameter int unsigned CLKS_PER_BIT   = 1
) (
  input logic                    clock_i,
  input logic                    reset_i,
  uart_counter_receiver_if.slave bus
);
  localparam int unsigned W       = $clog2(INPUT_FEATURES + 1);
  localparam logic [7:0]  LastCnt = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  HalfCnt = 8'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e       r_state;
  logic         r_armed;
  logic [7:0]   r_shift;
  logic [2:0]   r_bit_idx;
  logic [7:0]   r_cnt;
  logic [7:0]   r_data;
  logic [W-1:0] r_counter;
  logic         r_valid;
  logic         r_overflow;
  logic         r_frame_error;
  logic         r_busy;
  logic         w_rx;

`ifdef UART_RECEIVER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.uart_receive_i};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = bus.uart_receive_i;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= StIdle;
      r_armed       <= 1'b0;
      r_shift       <= 8'd0;
      r_bit_idx     <= 3'd0;
      r_cnt         <= 8'd0;
      r_data        <= 8'd0;
      r_counter     <= '0;
      r_valid       <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_valid       <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // A line held low through reset must go high once before a start is trusted.
          if (w_rx) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_busy    <= 1'b1;
            r_cnt     <= 8'd0;
            r_bit_idx <= 3'd0;
            r_state   <= (CLKS_PER_BIT == 1) ? StData : StStart;
          end
        end
        StStart: begin
          if (r_cnt == HalfCnt) begin
            r_cnt <= 8'd0;
            if (w_rx) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_state <= StData;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StData: begin
          if (r_cnt == LastCnt) begin
            r_cnt              <= 8'd0;
            r_shift[r_bit_idx] <= w_rx;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= StStop;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StStop: begin
          if (r_cnt == LastCnt) begin
            r_cnt <= 8'd0;
            if (w_rx) begin
              r_data     <= r_shift;
              r_counter  <= r_shift[W-1:0];
              r_overflow <= |(r_shift >> W);
              r_valid    <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= StIdle;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= StBreak;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StBreak: begin
          if (w_rx) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.data_o        = r_data;
  assign bus.counter_o     = r_counter;
  assign bus.data_valid_o  = r_valid;
  assign bus.overflow_o    = r_overflow;
  assign bus.frame_error_o = r_frame_error;
  assign bus.busy_o        = r_busy;
endmodule
